// File: rtl/req_arb_pkg.sv
// req_arb_pkg: state encoding, beat-counter width and length helper shared by req_arbiter.
// Beat count follows the bridge's wrap-decrement: a length field of 0 means 8 beats.
package req_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } req_arb_state_t;

  localparam int CNT_W = 4;

  typedef struct packed {
    req_arb_state_t   state;
    logic [1:0]       rr_ptr;
    logic [CNT_W-1:0] beat_cnt;
  } req_arb_dbg_t;

  function automatic logic [CNT_W-1:0] len_to_beats(input logic [CNT_W-2:0] len);
    return (len == '0) ? CNT_W'(8) : {1'b0, len};
  endfunction

endpackage

// File: rtl/req_arbiter_if.sv
// req_arbiter_if: requester-side and bridge-side channels of the burst arbiter.
// slave is the arbiter's view; master is the view of the requesters plus the bridge.
interface req_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int LEN_W   = 3,
  parameter int AW      = 32,
  parameter int DW      = 32
);
  localparam int COLS = DW / 8;

  // Every channel uses the same handshake: a beat or request moves on a rising
  // clock edge where its valid (or write strobe) and the matching ready/ack are high.
  logic [NUM_REQ-1:0]       m_req_valid;
  logic [NUM_REQ-1:0]       m_req_ready;
  logic [NUM_REQ*AW-1:0]    m_req_addr;
  logic [NUM_REQ*COLS-1:0]  m_req_mask;
  logic [NUM_REQ*LEN_W-1:0] m_req_len;
  logic [NUM_REQ-1:0]       m_req_we;
  logic [NUM_REQ-1:0]       m_write_valid;
  logic [NUM_REQ*DW-1:0]    m_write_data;
  logic [NUM_REQ-1:0]       m_read_valid;
  logic [DW-1:0]            m_read_data;
  logic [NUM_REQ-1:0]       m_read_ack;

  logic                     req_valid;
  logic                     req_ready;
  logic [AW-1:0]            req_addr;
  logic [COLS-1:0]          req_mask;
  logic [LEN_W-1:0]         req_len;
  logic                     req_we;
  logic                     write_valid;
  logic [DW-1:0]            write_data;
  logic                     read_valid;
  logic [DW-1:0]            read_data;
  logic                     read_ack;

  modport slave (
    input  m_req_valid, m_req_addr, m_req_mask, m_req_len, m_req_we,
    input  m_write_valid, m_write_data, m_read_ack,
    output m_req_ready, m_read_valid, m_read_data,
    input  req_ready, read_valid, read_data,
    output req_valid, req_addr, req_mask, req_len, req_we,
    output write_valid, write_data, read_ack
  );

  modport master (
    output m_req_valid, m_req_addr, m_req_mask, m_req_len, m_req_we,
    output m_write_valid, m_write_data, m_read_ack,
    input  m_req_ready, m_read_valid, m_read_data,
    output req_ready, read_valid, read_data,
    input  req_valid, req_addr, req_mask, req_len, req_we,
    input  write_valid, write_data, read_ack
  );

endinterface

// File: rtl/req_arbiter_rr_pick.sv
// rr_pick: combinational picker returning a one-hot grant and index of the winning request.
// Round-robin from ptr by default; REQ_ARB_FIXED_PRIO_EN selects lowest index wins.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic [N-1:0] grant,
  output logic [1:0]   idx
);

  int best_d;
  int d;

  // Each candidate gets a distance from the search start; the nearest asserted one wins.
  always_comb begin
    idx    = '0;
    grant  = '0;
    best_d = N;
    d      = 0;
    for (int c = 0; c < N; c++) begin
`ifdef REQ_ARB_FIXED_PRIO_EN
      d = c;
`else
      d = (c + N - int'(ptr)) % N;
`endif
      if (req[c] && (d < best_d)) begin
        best_d = d;
        idx    = 2'(c);
      end
    end
    for (int c = 0; c < N; c++) begin
      grant[c] = (best_d < N) && (idx == 2'(c));
    end
  end

endmodule

// File: rtl/req_arbiter.sv
// req_arbiter: shares one req_wb_bridge request/write/read channel set among NUM_REQ requesters.
// Per-burst grant; define REQ_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module req_arbiter
  import req_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LEN_W   = 3,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  req_arbiter_if.slave bus,
  output logic         busy,
  output logic [1:0]   owner,
  output req_arb_dbg_t dbg
);

  localparam int COLS = DW / 8;

  req_arb_state_t   state;
  logic [1:0]       rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic             we_r;

  logic [NUM_REQ-1:0] pick_grant;
  logic [1:0]         pick_idx;
  logic               pick_any;
  logic [LEN_W-1:0]   pick_len;
  logic               pick_we;

  logic [NUM_REQ-1:0] own_oh;
  logic [AW-1:0]      own_addr;
  logic [COLS-1:0]    own_mask;
  logic [LEN_W-1:0]   own_len;
  logic               own_we;
  logic               own_wvalid;
  logic [DW-1:0]      own_wdata;
  logic               own_rack;
  logic               beat;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (bus.m_req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign pick_any = |pick_grant;

  // Flattened requester buses demuxed by the registered owner and by the candidate winner.
  always_comb begin
    own_oh     = '0;
    own_addr   = '0;
    own_mask   = '0;
    own_len    = '0;
    own_we     = 1'b0;
    own_wvalid = 1'b0;
    own_wdata  = '0;
    own_rack   = 1'b0;
    pick_len   = '0;
    pick_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == 2'(i)) begin
        own_oh[i]  = 1'b1;
        own_addr   = bus.m_req_addr[i*AW +: AW];
        own_mask   = bus.m_req_mask[i*COLS +: COLS];
        own_len    = bus.m_req_len[i*LEN_W +: LEN_W];
        own_we     = bus.m_req_we[i];
        own_wvalid = bus.m_write_valid[i];
        own_wdata  = bus.m_write_data[i*DW +: DW];
        own_rack   = bus.m_read_ack[i];
      end
      if (pick_idx == 2'(i)) begin
        pick_len = bus.m_req_len[i*LEN_W +: LEN_W];
        pick_we  = bus.m_req_we[i];
      end
    end
  end

  assign bus.req_valid   = (state == REQ);
  assign bus.req_addr    = own_addr;
  assign bus.req_mask    = own_mask;
  assign bus.req_len     = own_len;
  assign bus.req_we      = own_we;
  assign bus.m_req_ready = own_oh & {NUM_REQ{(state == REQ) && bus.req_ready}};

  assign bus.write_valid  = (state == DATA) && we_r && own_wvalid;
  assign bus.write_data   = own_wdata;
  assign bus.m_read_valid = own_oh & {NUM_REQ{(state == DATA) && !we_r && bus.read_valid}};
  assign bus.m_read_data  = bus.read_data;
  assign bus.read_ack     = (state == DATA) && !we_r && own_rack && bus.read_valid;

  assign beat = bus.write_valid || bus.read_ack;
  assign busy = (state != IDLE);
  assign dbg  = '{state: state, rr_ptr: rr_ptr, beat_cnt: beat_cnt};

`ifdef REQ_ARB_FIXED_PRIO_EN
  assign rr_ptr = 2'd0;
`else
  logic [1:0] next_ptr;
  assign next_ptr = (owner == 2'(NUM_REQ - 1)) ? 2'd0 : owner + 2'd1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      owner    <= '0;
      beat_cnt <= '0;
      we_r     <= 1'b0;
`ifndef REQ_ARB_FIXED_PRIO_EN
      rr_ptr   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            owner    <= pick_idx;
            we_r     <= pick_we;
            beat_cnt <= len_to_beats(pick_len);
            state    <= REQ;
          end
        end
        REQ: begin
          if (bus.req_ready) state <= DATA;
        end
        DATA: begin
          if (beat) begin
            beat_cnt <= beat_cnt - 1'b1;
            if (beat_cnt == CNT_W'(1)) begin
              state  <= IDLE;
`ifndef REQ_ARB_FIXED_PRIO_EN
              rr_ptr <= next_ptr;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/req_arbiter.md
Name: req_arbiter

Overview:
- Shares one req_wb_bridge request/write/read channel set between NUM_REQ requesters, e.g. CPU bus port, DMA and video fetch.
- Arbitrates per burst: the winner owns the request, write-data and read-data channels until all beats of its burst have moved.
- Sits between the requesters and the bridge; the bridge's Wishbone side is untouched.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- LEN_W, 3, burst length field width; matches the bridge.
- AW, 32, address width.
- DW, 32, data width; COLS = DW/8.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- m_req_valid  in  NUM_REQ  per-requester request valid.
- m_req_ready  out  NUM_REQ  per-requester request accept.
- m_req_addr  in  NUM_REQ*AW  flattened; requester i at [i*AW +: AW].
- m_req_mask  in  NUM_REQ*COLS  flattened byte mask.
- m_req_len  in  NUM_REQ*LEN_W  flattened beat count.
- m_req_we  in  NUM_REQ  write flag.
- m_write_valid  in  NUM_REQ  write beat strobe.
- m_write_data  in  NUM_REQ*DW  flattened write data.
- m_read_valid  out  NUM_REQ  read beat available to owner.
- m_read_data  out  DW  broadcast read data.
- m_read_ack  in  NUM_REQ  read beat consume.
- req_valid, req_ready, req_addr, req_mask, req_len, req_we: downstream request channel; req_ready is an input.
- write_valid, write_data: downstream write channel (out).
- read_valid (in), read_data (in), read_ack (out): downstream read channel.
- busy  out  1  high in any state except IDLE.
- owner  out  2  index of the current grant holder.

Behaviour:
- Clock is clk_i. Reset rst_i is synchronous, active-high.
- Reset values: state=IDLE, owner=0, rr_ptr=0, beat counter=0, all valid/ready/ack outputs 0.
- Reset mid-burst abandons the burst; the bridge shares rst_i and flushes its FIFOs.

States: IDLE, REQ, DATA.
- IDLE:
  - If any m_req_valid is high, pick a winner round-robin, starting the search at rr_ptr.
  - Register owner, the winner's we and its beat count, then go to REQ.
  - Latency: one cycle from m_req_valid to req_valid.
- REQ:
  - req_valid=1. req_addr/mask/len/we are combinationally muxed from owner.
  - m_req_ready[owner] = req_ready; all other m_req_ready are 0.
  - On req_valid & req_ready, go to DATA.
  - The requester must hold its request stable until accepted.
- DATA:
  - Write burst: write_valid = m_write_valid[owner] and write_data is muxed from owner. Each write_valid decrements the counter.
  - Read burst: m_read_valid[owner] = read_valid; read_ack = m_read_ack[owner] & read_valid. Each read_ack decrements the counter.
  - Non-owners see m_read_valid=0, and their m_write_valid is ignored.
  - When a decrement takes the counter from 1 to 0: go to IDLE and set rr_ptr = owner+1, mod NUM_REQ.

Beat counting and boundary conditions:
- Beat count = req_len, except len 0 means 8 beats. This matches the bridge's wrap-decrement. The counter is 4 bits wide.
- Write beats may arrive only after the requester's request handshake; earlier beats are dropped.
- No write backpressure: the bridge FIFO depth must be at least 8.
- A requester asserting m_req_valid again while DATA is ongoing is not granted until the next IDLE.
- A winning request is never preempted.
- Minimum gap between bursts is 1 IDLE cycle.
- Simultaneous final beat and a new m_req_valid: the new request is evaluated in the following IDLE cycle.

Optional Feature:
- Macro: REQ_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is neither implemented nor updated.
- Undefined: round-robin as described above.

Decomposition:
- Package req_arb_pkg holds:
  - state encoding (IDLE=0, REQ=1, DATA=2);
  - the 4-bit beat-counter width;
  - a function converting len to a beat count (0 maps to 8).
- One sub-module, rr_pick: combinational priority picker with inputs req vector and ptr, outputs one-hot grant and index. It also implements the fixed-priority variant.

Test Plan:
- Lone read: m_req_valid[0], len=4, addr 0x100 → req_valid one cycle later with addr 0x100; four read_ack beats; busy drops after the 4th; owner=0.
- Contention: requesters 0 and 1 both request len=1 in the same cycle → grants go 0 then 1 (round-robin). With REQ_ARB_FIXED_PRIO_EN and requester 0 re-requesting, requester 0 is granted twice in a row.
- Write routing: requester 1 write, len=2, data 0xA5A5A5A5 and 0x5A5A5A5A; requester 0 toggles m_write_valid concurrently → downstream write_valid pulses exactly twice carrying requester 1's data.
- Length 0: read with len=0 → exactly 8 read_ack beats before IDLE.
- Read isolation: during requester 1's read, m_read_valid[0] stays 0 and m_read_ack[0] is ignored.
- Reset: rst_i asserted in DATA after 2 of 4 beats → next cycle state=IDLE, all outputs 0, rr_ptr=0.
